// File: rtl/qdec_pkg.sv
// Shared types and phase constants for the quadrature decoder.
package qdec_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  typedef logic [1:0] phase_t;

  // Forward (count-up) Gray sequence: 00 -> 01 -> 11 -> 10 -> 00
  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  function automatic phase_t fwd_next(input phase_t p);
    phase_t n;
    case (p)
      PH_00:   n = PH_01;
      PH_01:   n = PH_11;
      PH_11:   n = PH_10;
      default: n = PH_00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_decoder_sync2.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes A/B, tracks phase, counts position.
// Define GLITCH_FILTER_EN to require 3 identical synchronized samples before a phase is accepted.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         c,
  input  logic         r,
  input  logic         a,
  input  logic         b,
  input  logic         clr,
  output logic [W-1:0] o,
  output logic         dir,
  output logic         step,
  output logic         err
);

  localparam int unsigned FILL_W = 3;

  logic   a_s;
  logic   b_s;
  phase_t s_raw;
  phase_t s;

  sync2 u_sync_a (
    .clk_i (c),
    .rst_i (r),
    .d_i   (a),
    .q_o   (a_s)
  );

  sync2 u_sync_b (
    .clk_i (c),
    .rst_i (r),
    .d_i   (b),
    .q_o   (b_s)
  );

  assign s_raw = {a_s, b_s};

`ifdef GLITCH_FILTER_EN
  // Two extra history stages; INIT must wait for them to fill as well.
  localparam int unsigned FILL = 4;

  phase_t h1_q;
  phase_t h2_q;
  phase_t hold_q;
  logic   stable_c;

  assign stable_c = (s_raw == h1_q) && (h1_q == h2_q);
  assign s        = stable_c ? s_raw : hold_q;

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      h1_q   <= PH_00;
      h2_q   <= PH_00;
      hold_q <= PH_00;
    end else begin
      h1_q   <= s_raw;
      h2_q   <= h1_q;
      hold_q <= s;
    end
  end
`else
  localparam int unsigned FILL = 2;

  assign s = s_raw;
`endif

  state_e            state_q;
  phase_t            prev_q;
  logic [FILL_W-1:0] fill_q;
  logic [W-1:0]      o_q;
  logic              dir_q;
  logic              step_q;
  logic              err_q;

  logic same_c;
  logic fwd_c;
  logic rev_c;

  assign same_c = (s == prev_q);
  assign fwd_c  = (s == fwd_next(prev_q));
  assign rev_c  = (prev_q == fwd_next(s));

  // Phase tracker; clr overrides only the count, dir/step still follow the step.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state_q <= INIT;
      prev_q  <= PH_00;
      fill_q  <= '0;
      o_q     <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        INIT: begin
          if (fill_q == FILL_W'(FILL)) begin
            prev_q  <= s;
            state_q <= TRACK;
          end else begin
            fill_q <= fill_q + FILL_W'(1);
          end
        end
        TRACK: begin
          prev_q <= s;
          if (fwd_c) begin
            o_q    <= o_q + W'(1);
            dir_q  <= 1'b1;
            step_q <= 1'b1;
          end else if (rev_c) begin
            o_q    <= o_q - W'(1);
            dir_q  <= 1'b0;
            step_q <= 1'b1;
          end else if (!same_c) begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
      if (clr) begin
        o_q <= '0;
      end
    end
  end

  assign o    = o_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;

endmodule
